conv_layer_param: RTL and testbench

CONV_LAYER_PARAM -- requirements
Module: conv_layer_param

---
 rtl/conv_layer_param.sv | 111 +++++++++++
 tb/tb_conv_layer_param.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_param.sv
// conv_layer_param: sequential single-MAC 2D convolution layer with saturating fixed-point output
module conv_layer_param #(
    parameter int DW     = 16,
    parameter int FRAC   = 8,
    parameter int H      = 32,
    parameter int W      = 32,
    parameter int CH     = 1,
    parameter int K      = 5,
    parameter int NF     = 6,
    parameter int STRIDE = 1
) (
    input  logic                                                      clk,
    input  logic                                                      reset,
    input  logic                                                      start,
    input  logic                                                      relu_en,
    input  logic [CH*H*W*DW-1:0]                                      image,
    input  logic [NF*CH*K*K*DW-1:0]                                   filters,
    output logic                                                      busy,
    output logic                                                      done,
    output logic [NF*((H-K)/STRIDE+1)*((W-K)/STRIDE+1)*DW-1:0]        outputConv
);
    localparam int OH    = (H - K) / STRIDE + 1;
    localparam int OW    = (W - K) / STRIDE + 1;
    localparam int NT    = CH * K * K;
    localparam int ACC_W = 2 * DW + $clog2(NT);
    localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;
    state_t                    r_state;
    logic [31:0]               r_f, r_r, r_cc, r_c, r_ky, r_kx;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_relu, r_busy, r_done;
    logic [$bits(outputConv)-1:0] r_out;
    logic [31:0]               w_img_idx, w_flt_idx, w_out_idx;
    logic signed [DW-1:0]      w_pix, w_wgt;
    logic signed [2*DW-1:0]    w_prod;
    logic signed [ACC_W-1:0]   w_sum, w_sh;
    logic [DW-1:0]             w_sat, w_res;
    logic                      w_last_tap, w_last_elem;
    // tap addressing, full-width product, and shift/saturate/ReLU of the finished sum
    always_comb begin
        w_img_idx   = ((r_c * H + r_r * STRIDE + r_ky) * W + r_cc * STRIDE + r_kx) * DW;
        w_flt_idx   = (((r_f * CH + r_c) * K + r_ky) * K + r_kx) * DW;
        w_out_idx   = ((r_f * OH + r_r) * OW + r_cc) * DW;
        w_pix       = image[w_img_idx +: DW];
        w_wgt       = filters[w_flt_idx +: DW];
        w_prod      = w_pix * w_wgt;
        w_sum       = r_acc + ACC_W'(w_prod);
        w_sh        = r_acc >>> FRAC;
        w_sat       = w_sh > SMAX ? SMAX[DW-1:0] : w_sh < SMIN ? SMIN[DW-1:0] : w_sh[DW-1:0];
        w_res       = (r_relu && w_sat[DW-1]) ? '0 : w_sat;
        w_last_tap  = (r_c == CH - 1) && (r_ky == K - 1) && (r_kx == K - 1);
        w_last_elem = (r_f == NF - 1) && (r_r == OH - 1) && (r_cc == OW - 1);
    end
    // control FSM: one MAC per tap, one WRITE per output element, one-cycle DONE pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_f     <= '0;
            r_r     <= '0;
            r_cc    <= '0;
            r_c     <= '0;
            r_ky    <= '0;
            r_kx    <= '0;
            r_acc   <= '0;
            r_relu  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= MAC;
                    r_relu  <= relu_en;
                    r_busy  <= 1'b1;
                    r_acc   <= '0;
                    r_f     <= '0;
                    r_r     <= '0;
                    r_cc    <= '0;
                    r_c     <= '0;
                    r_ky    <= '0;
                    r_kx    <= '0;
                end
                MAC: begin
                    r_acc <= w_sum;
                    r_kx  <= (r_kx == K - 1) ? '0 : r_kx + 1;
                    r_ky  <= (r_kx != K - 1) ? r_ky : (r_ky == K - 1) ? '0 : r_ky + 1;
                    r_c   <= (r_kx != K - 1 || r_ky != K - 1) ? r_c : (r_c == CH - 1) ? '0 : r_c + 1;
                    if (w_last_tap) r_state <= WRITE;
                end
                WRITE: begin
                    r_out[w_out_idx +: DW] <= w_res;
                    r_acc <= '0;
                    r_cc  <= (r_cc == OW - 1) ? '0 : r_cc + 1;
                    r_r   <= (r_cc != OW - 1) ? r_r : (r_r == OH - 1) ? '0 : r_r + 1;
                    r_f   <= (r_cc != OW - 1 || r_r != OH - 1) ? r_f : (r_f == NF - 1) ? '0 : r_f + 1;
                    r_state <= w_last_elem ? DONE : MAC;
                    r_busy  <= !w_last_elem;
                    r_done  <= w_last_elem;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
    assign busy       = r_busy;
    assign done       = r_done;
    assign outputConv = r_out;
endmodule

// File: tb/tb_conv_layer_param.sv
// tb_conv_layer_param: directed and randomized checks of the convolution layer across four configurations
module tb_conv_layer_param;
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] st = '0, rl = '0;
    wire  [3:0] bz, dn;
    int vectors = 0, miscompares = 0;
    // u1: 4x4 image, 3x3 kernel, Q16.0
    logic [255:0] img1;
    logic [143:0] flt1;
    wire  [63:0]  out1;
    // u2: 8-bit, 3x3 image, 3x3 kernel
    logic [71:0]  img2, flt2;
    wire  [7:0]   out2;
    // u3: 5x5 image, 3x3 kernel, stride 2
    logic [399:0] img3;
    logic [143:0] flt3;
    wire  [63:0]  out3;
    // u4: Q8.8, 2 channels, 6x5 image, 2 filters
    logic [959:0] img4;
    logic [575:0] flt4;
    wire  [383:0] out4;
    longint img_a[], flt_a[];
    always #5 clk = ~clk;
    conv_layer_param #(.DW(16), .FRAC(0), .H(4), .W(4), .CH(1), .K(3), .NF(1), .STRIDE(1)) u1 (
        .clk(clk), .reset(rst), .start(st[0]), .relu_en(rl[0]), .image(img1), .filters(flt1),
        .busy(bz[0]), .done(dn[0]), .outputConv(out1));
    conv_layer_param #(.DW(8), .FRAC(0), .H(3), .W(3), .CH(1), .K(3), .NF(1), .STRIDE(1)) u2 (
        .clk(clk), .reset(rst), .start(st[1]), .relu_en(rl[1]), .image(img2), .filters(flt2),
        .busy(bz[1]), .done(dn[1]), .outputConv(out2));
    conv_layer_param #(.DW(16), .FRAC(0), .H(5), .W(5), .CH(1), .K(3), .NF(1), .STRIDE(2)) u3 (
        .clk(clk), .reset(rst), .start(st[2]), .relu_en(rl[2]), .image(img3), .filters(flt3),
        .busy(bz[2]), .done(dn[2]), .outputConv(out3));
    conv_layer_param #(.DW(16), .FRAC(8), .H(6), .W(5), .CH(2), .K(3), .NF(2), .STRIDE(1)) u4 (
        .clk(clk), .reset(rst), .start(st[3]), .relu_en(rl[3]), .image(img4), .filters(flt4),
        .busy(bz[3]), .done(dn[3]), .outputConv(out4));
    // one comparison: counted, reported with tag/observed/expected on failure
    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // golden value of one output element straight from the convolution definition
    function automatic longint ref_elem(input int dw, frac, h, w, ch, k, s, input bit relu,
                                        input int f, r, cc, input longint img[], input longint flt[]);
        longint acc = 0, hi, lo;
        for (int c = 0; c < ch; c++)
            for (int ky = 0; ky < k; ky++)
                for (int kx = 0; kx < k; kx++)
                    acc += img[(c * h + r * s + ky) * w + cc * s + kx] * flt[((f * ch + c) * k + ky) * k + kx];
        acc = acc >>> frac;
        hi = (longint'(1) <<< (dw - 1)) - 1;
        lo = -hi - 1;
        acc = acc > hi ? hi : acc < lo ? lo : acc;
        return (relu && acc < 0) ? 0 : acc;
    endfunction
    // start pulse, then count busy cycles (mode 1: toggle relu_en, mode 2: re-pulse start while busy)
    task automatic run(input int u, input int mode, input int exp_busy);
        int n = 0;
        st[u] = 1'b1;
        @(posedge clk); #1;
        st[u] = 1'b0;
        while (bz[u] && n < 5000) begin
            n++;
            if (mode == 1) rl[u] = ~rl[u];
            if (mode == 2) st[u] = (n == 5);
            @(posedge clk); #1;
        end
        st[u] = 1'b0;
        chk("busy_cycles", 512'(n), 512'(exp_busy));
        chk("done_high", 512'(dn[u]), 512'(1));
        @(posedge clk); #1;
        chk("done_single", 512'(dn[u]), 512'(0));
        chk("idle_after_done", 512'(bz[u]), 512'(0));
    endtask
    // randomize u4 data (full or narrow range), run, and compare every element with the model
    task automatic run_u4(input bit wide);
        longint v, e;
        bit relu;
        img_a = new[60];
        flt_a = new[36];
        for (int i = 0; i < 60; i++) begin
            v = wide ? longint'($urandom_range(0, 65535)) - 32768 : longint'($urandom_range(0, 1023)) - 512;
            img_a[i] = v;
            img4[i*16 +: 16] = v[15:0];
        end
        for (int i = 0; i < 36; i++) begin
            v = wide ? longint'($urandom_range(0, 65535)) - 32768 : longint'($urandom_range(0, 1023)) - 512;
            flt_a[i] = v;
            flt4[i*16 +: 16] = v[15:0];
        end
        relu = 1'($urandom_range(0, 1));
        rl[3] = relu;
        run(3, 0, 24 * 19);
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 3; c++) begin
                    e = ref_elem(16, 8, 6, 5, 2, 3, 1, relu, f, r, c, img_a, flt_a);
                    chk("u4_elem", 512'(out4[((f * 4 + r) * 3 + c) * 16 +: 16]), 512'(e[15:0]));
                end
    endtask
    initial begin
        longint v, e;
        img1 = '0; flt1 = '0; img2 = '0; flt2 = '0; img3 = '0; flt3 = '0; img4 = '0; flt4 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 512'(bz), 512'(0));
        chk("reset_done", 512'(dn), 512'(0));
        chk("reset_out1", 512'(out1), 512'(0));
        chk("reset_out4", 512'(out4), 512'(0));
        rst = 1'b0;
        // all-ones 4x4 with ones kernel: every sum is 9, start accepted on first edge after reset
        for (int i = 0; i < 16; i++) img1[i*16 +: 16] = 16'h0001;
        for (int i = 0; i < 9; i++) flt1[i*16 +: 16] = 16'h0001;
        run(0, 0, 40);
        chk("ones_out", 512'(out1), 512'({4{16'h0009}}));
        // -1 kernel without and with ReLU (relu_en toggling while busy must not matter)
        for (int i = 0; i < 9; i++) flt1[i*16 +: 16] = 16'hFFFF;
        rl[0] = 1'b0;
        run(0, 0, 40);
        chk("neg_out", 512'(out1), 512'({4{16'hFFF7}}));
        rl[0] = 1'b1;
        run(0, 1, 40);
        chk("relu_out", 512'(out1), 512'(0));
        rl[0] = 1'b0;
        // start re-asserted mid-run: no restart, same busy length and results
        run(0, 2, 40);
        chk("restart_ignored_out", 512'(out1), 512'({4{16'hFFF7}}));
        // 8-bit saturation both ways
        for (int i = 0; i < 9; i++) begin img2[i*8 +: 8] = 8'h7F; flt2[i*8 +: 8] = 8'h7F; end
        run(1, 0, 10);
        chk("sat_pos", 512'(out2), 512'(8'h7F));
        for (int i = 0; i < 9; i++) flt2[i*8 +: 8] = 8'h80;
        run(1, 0, 10);
        chk("sat_neg", 512'(out2), 512'(8'h80));
        // stride 2 over an x-coordinate ramp: rows read 9, 27
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++) img3[(y * 5 + x)*16 +: 16] = 16'(x);
        for (int i = 0; i < 9; i++) flt3[i*16 +: 16] = 16'h0001;
        run(2, 0, 40);
        chk("stride_out", 512'(out3), 512'({16'h001B, 16'h0009, 16'h001B, 16'h0009}));
        // random u1 data against the model, with a mid-MAC async reset first
        img_a = new[16];
        flt_a = new[9];
        for (int i = 0; i < 16; i++) begin
            v = longint'($urandom_range(0, 2047)) - 1024;
            img_a[i] = v;
            img1[i*16 +: 16] = v[15:0];
        end
        for (int i = 0; i < 9; i++) begin
            v = longint'($urandom_range(0, 63)) - 32;
            flt_a[i] = v;
            flt1[i*16 +: 16] = v[15:0];
        end
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_busy", 512'(bz[0]), 512'(0));
        chk("async_rst_done", 512'(dn[0]), 512'(0));
        chk("async_rst_out", 512'(out1), 512'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        run(0, 0, 40);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                e = ref_elem(16, 0, 4, 4, 1, 3, 1, 1'b0, 0, r, c, img_a, flt_a);
                chk("u1_rand_elem", 512'(out1[(r * 2 + c)*16 +: 16]), 512'(e[15:0]));
            end
        // start held high: relaunch from IDLE on the cycle after DONE
        st[0] = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 200 && !dn[0]; n++) begin @(posedge clk); #1; end
        chk("held_done", 512'(dn[0]), 512'(1));
        @(posedge clk); #1;
        chk("held_idle", 512'(bz[0]), 512'(0));
        @(posedge clk); #1;
        st[0] = 1'b0;
        chk("held_relaunch", 512'(bz[0]), 512'(1));
        for (int n = 0; n < 200 && !dn[0]; n++) begin @(posedge clk); #1; end
        chk("held_second_done", 512'(dn[0]), 512'(1));
        @(posedge clk); #1;
        // multi-channel, multi-filter Q8.8 randomized runs
        run_u4(1'b1);
        run_u4(1'b0);
        run_u4(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
